// File: rtl/score_display_if.sv
// score_display_if: score input and 7-segment display bundle
//   score_in  : binary score from the playfield stage
//   show_best : view select for the best score
//   an, seg   : active-low anodes and segments {g,f,e,d,c,b,a}
//   dp        : active-low decimal point
//   busy      : conversion in progress
//   modports  : master drives score_in/show_best, slave drives the display and busy
interface score_display_if;
  logic [15:0] score_in;
  logic show_best;
  logic [3:0] an;
  logic [6:0] seg;
  logic dp;
  logic busy;
  modport master(output score_in, show_best, input an, seg, dp, busy);
  modport slave(input score_in, show_best, output an, seg, dp, busy);
endinterface

// File: rtl/score_display.sv
// score_display: saturate a binary score, convert it to BCD by double dabble, scan it onto a 4-digit 7-segment display
//   clk   : system clock
//   reset : asynchronous active-high reset
//   bus   : score_display_if.slave (score_in, show_best in; an, seg, dp, busy out)
//   Optional macro SCORE_DISPLAY_HIGH_SCORE_EN: tracks the best score and shows it while show_best is high
module score_display #(
  parameter int REFRESH_DIV = 100000,
  parameter int SAT_MAX = 9999
) (
  input logic clk,
  input logic reset,
  score_display_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  localparam int CW = $clog2(REFRESH_DIV);
  localparam logic [6:0] SEG_LUT [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                         7'h00, 7'h10, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
  state_t state, state_nx;
  logic [13:0] sat, latched, src;
  logic [29:0] sr;
  logic [3:0] iter;
  logic [15:0] bcd, shown;
  logic start, pick_b, tgt_b, sel_b, wrap, blank, dp_nx;
  logic [CW-1:0] cnt;
  logic [1:0] idx;
  logic [3:0] nib;

  // one double-dabble step over the {bcd[15:0], bin[13:0]} register
  function automatic logic [29:0] dabble(input logic [29:0] r);
    logic [29:0] t;
    t = r;
    for (int i = 0; i < 4; i++)
      if (t[14 + 4 * i +: 4] >= 4'd5) t[14 + 4 * i +: 4] = t[14 + 4 * i +: 4] + 4'd3;
    return {t[28:0], 1'b0};
  endfunction

  assign sat = bus.score_in > 16'(SAT_MAX) ? 14'(SAT_MAX) : bus.score_in[13:0];

`ifdef SCORE_DISPLAY_HIGH_SCORE_EN
  logic [13:0] best, latched_b;
  logic [15:0] bcd_b;
  logic last_s;
  // score wins when both are pending unless it was converted last, so the two alternate
  assign pick_b = best != latched_b && (sat == latched || last_s);
  assign start = sat != latched || best != latched_b;
  assign src = pick_b ? best : sat;
  assign shown = sel_b ? bcd_b : bcd;
  assign dp_nx = ~(sel_b && idx == 2'd3);
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      best <= '0;
      latched_b <= '0;
      bcd_b <= '0;
      last_s <= 1'b0;
      tgt_b <= 1'b0;
      sel_b <= 1'b0;
    end else begin
      if (sat > best) best <= sat;
      if (state == IDLE && start) begin
        tgt_b <= pick_b;
        last_s <= !pick_b;
        if (pick_b) latched_b <= best;
      end
      if (state == DONE && tgt_b) bcd_b <= sr[29:14];
      if (wrap) sel_b <= bus.show_best;
    end
`else
  assign pick_b = 1'b0;
  assign tgt_b = 1'b0;
  assign sel_b = 1'b0;
  assign start = sat != latched;
  assign src = sat;
  assign shown = bcd;
  assign dp_nx = 1'b1;
`endif

  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_nx;

  always_comb begin
    state_nx = state;
    state_nx = state == IDLE ? (start ? SHIFT : IDLE) :
               state == SHIFT ? (iter == 4'd13 ? DONE : SHIFT) : IDLE;
  end

  always_comb begin
    bus.busy = state != IDLE;
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      latched <= '0;
      sr <= '0;
      iter <= '0;
      bcd <= '0;
    end else if (state == IDLE && start) begin
      if (!pick_b) latched <= sat;
      sr <= {16'b0, src};
      iter <= '0;
    end else if (state == SHIFT) begin
      sr <= dabble(sr);
      iter <= iter + 4'd1;
    end else if (state == DONE && !tgt_b) begin
      bcd <= sr[29:14];
    end

  assign wrap = cnt == CW'(REFRESH_DIV - 1);
  assign nib = shown[{idx, 2'b00} +: 4];
  // blank when this digit and every higher one is zero; the units digit always shows
  assign blank = idx != 2'd0 && (shown >> {idx, 2'b00}) == 16'd0;

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      cnt <= '0;
      idx <= '0;
      bus.an <= 4'hF;
      bus.seg <= 7'h7F;
      bus.dp <= 1'b1;
    end else begin
      cnt <= wrap ? '0 : cnt + CW'(1);
      if (wrap) idx <= idx + 2'd1;
      bus.an <= ~(4'b0001 << idx);
      bus.seg <= blank ? 7'h7F : SEG_LUT[nib];
      bus.dp <= dp_nx;
    end
endmodule

// File: tb/tb_score_display.sv
// tb_score_display: randomized and directed checks of score_display against a decimal reference model
module tb_score_display;
  localparam int DIV = 4;
  logic clk = 1'b0;
  logic reset = 1'b0;
  score_display_if bus();
  score_display #(.REFRESH_DIV(DIV), .SAT_MAX(9999)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int cur = 0;
  int best_m = 0;
  logic sb = 1'b0;
  logic [6:0] digit_seg [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                 7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
  logic [15:0] bnd [5] = '{16'd0, 16'd1, 16'd9998, 16'd9999, 16'd10000};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] exp_seg(input int v, input int k);
    int p;
    p = 1;
    for (int i = 0; i < k; i++) p *= 10;
    return (k > 0 && v < p) ? 7'h7F : digit_seg[(v / p) % 10];
  endfunction

  task automatic settle();
    int q;
    q = 0;
    for (int w = 0; w < 300 && q < 3; w++) begin
      @(negedge clk);
      q = bus.busy ? 0 : q + 1;
    end
    check("settle", {31'b0, bus.busy}, 0);
  endtask

  task automatic conv(output int hi);
    int w;
    w = 0;
    hi = 0;
    while (!bus.busy && w < 4) begin
      @(negedge clk);
      w++;
    end
    while (bus.busy && hi < 40) begin
      hi++;
      @(negedge clk);
    end
  endtask

  task automatic frame();
    logic [6:0] sg [4];
    logic dd [4];
    logic [3:0] pa;
    int rl, v;
    bit first;
    for (int k = 0; k < 4; k++) begin
      sg[k] = 7'h55;
      dd[k] = 1'bx;
    end
    v = sb ? best_m : cur;
    repeat (4 * DIV + 2) @(negedge clk);
    pa = bus.an;
    rl = 0;
    first = 1;
    for (int c = 0; c < 8 * DIV; c++) begin
      check("an_onehot", $countones(~bus.an), 1);
      if (bus.an != pa) begin
        if (!first) check("an_run", rl, DIV);
        check("an_seq", {28'b0, bus.an}, {28'b0, pa[2:0], pa[3]});
        first = 0;
        pa = bus.an;
        rl = 0;
      end
      for (int k = 0; k < 4; k++)
        if (bus.an == ~(4'b0001 << k)) begin
          sg[k] = bus.seg;
          dd[k] = bus.dp;
        end
      rl++;
      @(negedge clk);
    end
    for (int k = 0; k < 4; k++) begin
      check($sformatf("seg%0d_v%0d", k, v), {25'b0, sg[k]}, {25'b0, exp_seg(v, k)});
      check($sformatf("dp%0d", k), {31'b0, dd[k]}, (sb && k == 3) ? 0 : 1);
    end
  endtask

  task automatic apply(input logic [15:0] v);
    int s, hi;
    s = int'(v) > 9999 ? 9999 : int'(v);
    @(negedge clk);
    bus.score_in = v;
    if (s != cur) begin
      conv(hi);
      check($sformatf("busy_len_%0d", s), hi, 15);
    end else begin
      hi = 0;
      repeat (20) begin
        @(negedge clk);
        if (bus.busy) hi++;
      end
      check($sformatf("quiet_%0d", s), hi, 0);
    end
    cur = s;
    if (s > best_m) best_m = s;
    settle();
    frame();
  endtask

  initial begin
    logic [15:0] v;
    int hi, lo;
    bus.score_in = 16'd0;
    bus.show_best = 1'b0;
    #3 reset = 1'b1;
    #1;
    check("rst_an", {28'b0, bus.an}, 32'hF);
    check("rst_seg", {25'b0, bus.seg}, 32'h7F);
    check("rst_dp", {31'b0, bus.dp}, 1);
    check("rst_busy", {31'b0, bus.busy}, 0);
    @(negedge clk);
    reset = 1'b0;
    settle();
    frame();
    apply(16'd42);
    apply(16'd12345);
    apply(16'd65535);
    apply(16'd1000);
    apply(16'd0);
    apply(16'd9999);
    apply(16'd10000);
    apply(16'd3);
    // a new value arriving mid-conversion is picked up right after the first finishes
    @(negedge clk);
    bus.score_in = 16'd5;
    hi = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.busy) hi++;
    end
    bus.score_in = 16'd7;
    while (bus.busy && hi < 40) begin
      @(negedge clk);
      if (bus.busy) hi++;
    end
    check("busy_len_first", hi, 15);
    lo = 0;
    while (!bus.busy && lo < 10) begin
      @(negedge clk);
      lo++;
    end
    check("idle_gap", lo, 1);
    hi = 0;
    while (bus.busy && hi < 40) begin
      hi++;
      @(negedge clk);
    end
    check("busy_len_second", hi, 15);
    cur = 7;
    if (best_m < 7) best_m = 7;
    settle();
    frame();
    // reset in the middle of a conversion
    @(negedge clk);
    bus.score_in = 16'd1234;
    repeat (5) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_an", {28'b0, bus.an}, 32'hF);
    check("mid_rst_seg", {25'b0, bus.seg}, 32'h7F);
    check("mid_rst_busy", {31'b0, bus.busy}, 0);
    bus.score_in = 16'd0;
    cur = 0;
    best_m = 0;
    @(negedge clk);
    reset = 1'b0;
    settle();
    frame();
`ifdef SCORE_DISPLAY_HIGH_SCORE_EN
    apply(16'd30);
    apply(16'd0);
    sb = 1'b1;
    bus.show_best = 1'b1;
    frame();
    sb = 1'b0;
    bus.show_best = 1'b0;
    frame();
`endif
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 4))
        0: v = 16'($urandom_range(0, 99));
        1: v = 16'($urandom_range(0, 9999));
        2: v = 16'($urandom_range(10000, 65535));
        3: v = bus.score_in;
        default: v = bnd[$urandom_range(0, 4)];
      endcase
      apply(v);
    end
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
